// File: rtl/decode_stage_if.sv
// Fetch-to-execute bundle around the decode stage: instruction input handshake
// plus the decoded head entry and its pop handshake.
interface decode_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ALU_W = 4
);

  localparam int unsigned INST_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CLS_W  = 3;

  logic                 in_valid;
  logic                 in_ready;
  logic [INST_W-1:0]    in_inst;
  logic [XLEN-1:0]      in_pc;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [REG_W-1:0]     rs1_num;
  logic [REG_W-1:0]     rs2_num;
  logic [REG_W-1:0]     rd_num;
  logic [XLEN-1:0]      imm;
  logic [ALU_W-1:0]     alu_control;
  logic [CLS_W-1:0]     inst_class;

  // Upstream/consumer side: drives instructions and the pop strobe.
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rs1_num, rs2_num, rd_num,
           imm, alu_control, inst_class
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rs1_num, rs2_num, rd_num,
           imm, alu_control, inst_class
  );

endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: combinational decode of the incoming word,
// captured into a 2-entry skid buffer whose head drives execute.
module decode_stage #(
  parameter int unsigned XLEN          = 32,
  parameter bit          ENABLE_BRANCH = 1'b1,
  parameter int unsigned ALU_W         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  decode_stage_if.slave bus
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CLS_W  = 3;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [CODE_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [CODE_W-1:0] ALU_SLL   = 4'b0001;
  localparam logic [CODE_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [CODE_W-1:0] ALU_OR    = 4'b0011;
  localparam logic [CODE_W-1:0] ALU_SUB   = 4'b0100;
  localparam logic [CODE_W-1:0] ALU_SLT   = 4'b0101;
  localparam logic [CODE_W-1:0] ALU_XOR   = 4'b0110;
  localparam logic [CODE_W-1:0] ALU_SLTU  = 4'b0111;
  localparam logic [CODE_W-1:0] ALU_SRL   = 4'b1000;
  localparam logic [CODE_W-1:0] ALU_SRA   = 4'b1001;
  localparam logic [CODE_W-1:0] ALU_STORE = 4'b1100;
  localparam logic [CODE_W-1:0] ALU_LOAD  = 4'b1101;
  localparam logic [CODE_W-1:0] ALU_BAD   = 4'b1111;

  localparam logic [CLS_W-1:0] CLS_R       = 3'd0;
  localparam logic [CLS_W-1:0] CLS_I       = 3'd1;
  localparam logic [CLS_W-1:0] CLS_LOAD    = 3'd2;
  localparam logic [CLS_W-1:0] CLS_STORE   = 3'd3;
  localparam logic [CLS_W-1:0] CLS_LUI     = 3'd4;
  localparam logic [CLS_W-1:0] CLS_AUIPC   = 3'd5;
  localparam logic [CLS_W-1:0] CLS_BRANCH  = 3'd6;
  localparam logic [CLS_W-1:0] CLS_ILLEGAL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   imm;
    logic [CODE_W-1:0] alu;
    logic [CLS_W-1:0]  cls;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Shared funct3 -> ALU mapping for register and immediate arithmetic.
  function automatic logic [CODE_W-1:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'd0:    alu_from_f3 = ALU_ADD;
      3'd1:    alu_from_f3 = ALU_SLL;
      3'd2:    alu_from_f3 = ALU_SLT;
      3'd3:    alu_from_f3 = ALU_SLTU;
      3'd4:    alu_from_f3 = ALU_XOR;
      3'd5:    alu_from_f3 = ALU_SRL;
      3'd6:    alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  logic [6:0]       opcode;
  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic [REG_W-1:0] rs1_f;
  logic [REG_W-1:0] rs2_f;
  logic [REG_W-1:0] rd_f;

  logic signed [11:0] i_raw;
  logic signed [11:0] s_raw;
  logic signed [12:0] b_raw;
  logic signed [31:0] u_raw;
  logic [XLEN-1:0]    i_imm;
  logic [XLEN-1:0]    s_imm;
  logic [XLEN-1:0]    b_imm;
  logic [XLEN-1:0]    u_imm;
  logic [XLEN-1:0]    sh_imm;

  assign opcode = bus.in_inst[6:0];
  assign rd_f   = bus.in_inst[11:7];
  assign funct3 = bus.in_inst[14:12];
  assign rs1_f  = bus.in_inst[19:15];
  assign rs2_f  = bus.in_inst[24:20];
  assign funct7 = bus.in_inst[31:25];

  assign i_raw  = bus.in_inst[31:20];
  assign s_raw  = {bus.in_inst[31:25], bus.in_inst[11:7]};
  assign b_raw  = {bus.in_inst[31], bus.in_inst[7], bus.in_inst[30:25],
                   bus.in_inst[11:8], 1'b0};
  assign u_raw  = {bus.in_inst[31:12], 12'b0};
  assign i_imm  = XLEN'(i_raw);
  assign s_imm  = XLEN'(s_raw);
  assign b_imm  = XLEN'(b_raw);
  assign u_imm  = XLEN'(u_raw);
  assign sh_imm = XLEN'(bus.in_inst[24:20]);

  entry_t dec;
  logic   legal;

  // Instruction decode; anything not recognised collapses to the illegal entry.
  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    dec.pc = bus.in_pc;
    case (opcode)
      OP_R: begin
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        dec.rd  = rd_f;
        dec.cls = CLS_R;
        if (funct7 == 7'h00)                          dec.alu = alu_from_f3(funct3);
        else if (funct7 == 7'h20 && funct3 == 3'd0)   dec.alu = ALU_SUB;
        else if (funct7 == 7'h20 && funct3 == 3'd5)   dec.alu = ALU_SRA;
        else                                          legal   = 1'b0;
      end
      OP_IMM: begin
        dec.rs1 = rs1_f;
        dec.rd  = rd_f;
        dec.cls = CLS_I;
        dec.imm = i_imm;
        dec.alu = alu_from_f3(funct3);
        if (funct3 == 3'd1) begin
          dec.imm = sh_imm;
          legal   = (funct7 == 7'h00);
        end else if (funct3 == 3'd5) begin
          dec.imm = sh_imm;
          dec.alu = bus.in_inst[30] ? ALU_SRA : ALU_SRL;
          legal   = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
      end
      OP_LOAD: begin
        dec.rs1 = rs1_f;
        dec.rd  = rd_f;
        dec.imm = i_imm;
        dec.alu = ALU_LOAD;
        dec.cls = CLS_LOAD;
      end
      OP_STORE: begin
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        dec.imm = s_imm;
        dec.alu = ALU_STORE;
        dec.cls = CLS_STORE;
      end
      OP_LUI: begin
        dec.rd  = rd_f;
        dec.imm = u_imm;
        dec.alu = ALU_ADD;
        dec.cls = CLS_LUI;
      end
      OP_AUIPC: begin
        dec.rd  = rd_f;
        dec.imm = u_imm;
        dec.alu = ALU_ADD;
        dec.cls = CLS_AUIPC;
      end
      OP_BRANCH: begin
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        dec.imm = b_imm;
        dec.alu = ALU_SUB;
        dec.cls = CLS_BRANCH;
        legal   = ENABLE_BRANCH && (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec     = '0;
      dec.pc  = bus.in_pc;
      dec.alu = ALU_BAD;
      dec.cls = CLS_ILLEGAL;
    end
  end

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   acc;
  logic   pop;

  assign acc = bus.in_valid & in_ready_q;
  assign pop = out_valid_q & bus.out_ready;

  // Skid buffer next-state: head is the entry presented to execute, tail the overflow slot.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            head_d  = dec;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            head_d = dec;
          end else if (acc) begin
            tail_d  = dec;
            state_d = TWO;
          end else if (pop) begin
            head_d  = '0;
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_d  = tail_q;
            tail_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
  end

  // Handshake flags are registered from the next state so neither depends on out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = head_q.pc;
  assign bus.rs1_num     = head_q.rs1;
  assign bus.rs2_num     = head_q.rs2;
  assign bus.rd_num      = head_q.rd;
  assign bus.imm         = head_q.imm;
  assign bus.alu_control = ALU_W'(head_q.alu);
  assign bus.inst_class  = head_q.cls;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: branch-enabled and branch-disabled instances share one
// stimulus stream and are scored against a queue-based reference model.
module tb_decode_stage;

  logic clk;
  logic rst_n;
  logic flush;

  decode_stage_if #(.XLEN(32), .ALU_W(4)) bus_b ();
  decode_stage_if #(.XLEN(32), .ALU_W(4)) bus_nb ();

  decode_stage #(.XLEN(32), .ENABLE_BRANCH(1'b1), .ALU_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b)
  );
  decode_stage #(.XLEN(32), .ENABLE_BRANCH(1'b0), .ALU_W(4)) dut_nb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] pc;
    bit [31:0] imm;
    int        rs1;
    int        rs2;
    int        rd;
    int        alu;
    int        cls;
  } exp_t;

  exp_t      qb[$];
  exp_t      qnb[$];
  int        passed;
  int        total;
  bit        zeroed;
  bit        cur_valid;
  bit        cur_ready;
  bit        cur_flush;
  bit [31:0] cur_inst;
  bit [31:0] cur_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else passed++;
  endtask

  task automatic drive(input bit v, input bit [31:0] inst, input bit [31:0] pc,
                       input bit ordy, input bit fl);
    cur_valid = v;  cur_inst = inst;  cur_pc = pc;  cur_ready = ordy;  cur_flush = fl;
    bus_b.in_valid   = v;   bus_nb.in_valid  = v;
    bus_b.in_inst    = inst; bus_nb.in_inst  = inst;
    bus_b.in_pc      = pc;  bus_nb.in_pc     = pc;
    bus_b.out_ready  = ordy; bus_nb.out_ready = ordy;
    flush            = fl;
  endtask

  // Reference decoder written straight from the instruction field rules.
  function automatic exp_t ref_decode(input bit [31:0] w, input bit [31:0] pc, input bit en_br);
    exp_t e;
    int   op, f3, f7, ii, si, bi;
    int   f3_alu[8];
    bit   ok;
    f3_alu = '{2, 1, 5, 7, 6, 8, 3, 0};
    op = int'(w[6:0]);  f3 = int'(w[14:12]);  f7 = int'(w[31:25]);
    ii = int'(w[31:20]);
    if (ii >= 2048) ii -= 4096;
    si = f7 * 32 + int'(w[11:7]);
    if (si >= 2048) si -= 4096;
    bi = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    if (bi >= 4096) bi -= 8192;
    e.pc = pc;  e.rs1 = int'(w[19:15]);  e.rs2 = int'(w[24:20]);  e.rd = int'(w[11:7]);
    e.imm = 32'd0;  e.alu = 15;  e.cls = 7;  ok = 1'b1;
    case (op)
      'h33: begin
        e.cls = 0;  e.imm = 32'd0;
        if (f7 == 0) e.alu = f3_alu[f3];
        else if (f7 == 32 && f3 == 0) e.alu = 4;
        else if (f7 == 32 && f3 == 5) e.alu = 9;
        else ok = 1'b0;
      end
      'h13: begin
        e.cls = 1;  e.rs2 = 0;  e.imm = 32'(ii);  e.alu = f3_alu[f3];
        if (f3 == 1) begin
          e.imm = 32'(w[24:20]);  ok = (f7 == 0);
        end else if (f3 == 5) begin
          e.imm = 32'(w[24:20]);
          if (f7 == 0) e.alu = 8;
          else if (f7 == 32) e.alu = 9;
          else ok = 1'b0;
        end
      end
      'h03: begin e.cls = 2; e.rs2 = 0; e.imm = 32'(ii); e.alu = 13; end
      'h23: begin e.cls = 3; e.rd = 0;  e.imm = 32'(si); e.alu = 12; end
      'h37: begin e.cls = 4; e.rs1 = 0; e.rs2 = 0; e.imm = w & 32'hFFFF_F000; e.alu = 2; end
      'h17: begin e.cls = 5; e.rs1 = 0; e.rs2 = 0; e.imm = w & 32'hFFFF_F000; e.alu = 2; end
      'h63: begin
        e.cls = 6;  e.rd = 0;  e.imm = 32'(bi);  e.alu = 4;
        if (!en_br || f3 == 2 || f3 == 3) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.rs1 = 0;  e.rs2 = 0;  e.rd = 0;  e.imm = 32'd0;  e.alu = 15;  e.cls = 7;
    end
    return e;
  endfunction

  function automatic bit [31:0] rand_legal();
    bit [4:0]  rd, rs1, rs2, lo5;
    bit [2:0]  f3;
    bit [6:0]  f7;
    bit [11:0] i12;
    bit [19:0] u20;
    int        f3_list[6];
    f3_list = '{0, 2, 3, 4, 6, 7};
    rd  = 5'($urandom);  rs1 = 5'($urandom);  rs2 = 5'($urandom);  lo5 = 5'($urandom);
    f3  = 3'($urandom);  f7  = 7'($urandom);  i12 = 12'($urandom); u20 = 20'($urandom);
    case ($urandom_range(0, 7))
      0: begin
        if ($urandom_range(0, 3) == 0) begin
          f7 = 7'h20;  f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
        end else f7 = 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      1: return {i12, rs1, 3'(f3_list[$urandom_range(0, 5)]), rd, 7'h13};
      2: begin
        f3 = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
        f7 = (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h13};
      end
      3: return {i12, rs1, f3, rd, 7'h03};
      4: return {f7, rs2, rs1, f3, lo5, 7'h23};
      5: return {u20, rd, 7'h37};
      6: return {u20, rd, 7'h17};
      default: return {f7, rs2, rs1, 3'(f3_list[$urandom_range(0, 5)]), lo5, 7'h63};
    endcase
  endfunction

  task automatic zero_checks(input string tag);
    check({tag, "_vld"},  64'(bus_b.out_valid), 64'd0);
    check({tag, "_vldn"}, 64'(bus_nb.out_valid), 64'd0);
    check({tag, "_data"}, 64'(|{bus_b.out_pc, bus_b.imm, bus_b.rs1_num, bus_b.rs2_num,
                                 bus_b.rd_num, bus_b.alu_control, bus_b.inst_class}), 64'd0);
    check({tag, "_datan"}, 64'(|{bus_nb.out_pc, bus_nb.imm, bus_nb.rs1_num, bus_nb.rs2_num,
                                  bus_nb.rd_num, bus_nb.alu_control, bus_nb.inst_class}), 64'd0);
  endtask

  task automatic compare_all();
    exp_t eb, en;
    check("in_ready",   64'(bus_b.in_ready),   64'(qb.size() < 2));
    check("in_ready_n", 64'(bus_nb.in_ready),  64'(qnb.size() < 2));
    check("out_valid",  64'(bus_b.out_valid),  64'(qb.size() > 0));
    check("out_valid_n",64'(bus_nb.out_valid), 64'(qnb.size() > 0));
    if (qb.size() > 0) begin
      eb = qb[0];
      en = qnb[0];
      check("pc",    64'(bus_b.out_pc),       64'(eb.pc));
      check("rs1",   64'(bus_b.rs1_num),      64'(eb.rs1));
      check("rs2",   64'(bus_b.rs2_num),      64'(eb.rs2));
      check("rd",    64'(bus_b.rd_num),       64'(eb.rd));
      check("imm",   64'(bus_b.imm),          64'(eb.imm));
      check("alu",   64'(bus_b.alu_control),  64'(eb.alu));
      check("class", 64'(bus_b.inst_class),   64'(eb.cls));
      check("pc_n",    64'(bus_nb.out_pc),      64'(en.pc));
      check("rs1_n",   64'(bus_nb.rs1_num),     64'(en.rs1));
      check("rs2_n",   64'(bus_nb.rs2_num),     64'(en.rs2));
      check("rd_n",    64'(bus_nb.rd_num),      64'(en.rd));
      check("imm_n",   64'(bus_nb.imm),         64'(en.imm));
      check("alu_n",   64'(bus_nb.alu_control), 64'(en.alu));
      check("class_n", 64'(bus_nb.inst_class),  64'(en.cls));
    end else if (zeroed) begin
      zero_checks("idle_zero");
    end
  endtask

  // Advance the model with the current inputs, clock once, then score the outputs.
  task automatic tick();
    bit acc, pop;
    acc = cur_valid && (qb.size() < 2);
    pop = cur_ready && (qb.size() > 0);
    if (cur_flush) begin
      qb.delete();  qnb.delete();  zeroed = 1'b1;
    end else begin
      if (pop) begin qb.delete(0); qnb.delete(0); end
      if (acc) begin
        qb.push_back(ref_decode(cur_inst, cur_pc, 1'b1));
        qnb.push_back(ref_decode(cur_inst, cur_pc, 1'b0));
        zeroed = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] pc;
    bit [31:0] w;
    int        cnt;
    passed = 0;  total = 0;  zeroed = 1'b1;  pc = 32'h0000_1000;
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    zero_checks("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(bus_b.in_ready), 64'd1);

    // addi x5,x1,-1 with consumer ready
    drive(1'b1, 32'hFFF0_8293, 32'h0000_0100, 1'b1, 1'b0);
    tick();
    check("addi_vld",   64'(bus_b.out_valid),   64'd1);
    check("addi_rd",    64'(bus_b.rd_num),      64'd5);
    check("addi_rs1",   64'(bus_b.rs1_num),     64'd1);
    check("addi_imm",   64'(bus_b.imm),         64'hFFFF_FFFF);
    check("addi_alu",   64'(bus_b.alu_control), 64'h2);
    check("addi_class", 64'(bus_b.inst_class),  64'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();

    // Backpressure: sub then sw with consumer stalled
    drive(1'b1, 32'h4020_8133, 32'h0000_0200, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0020_A223, 32'h0000_0204, 1'b0, 1'b0);
    tick();
    check("bp_full_ready", 64'(bus_b.in_ready), 64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      check("bp_hold_alu", 64'(bus_b.alu_control), 64'h4);
      check("bp_hold_pc",  64'(bus_b.out_pc),      64'h200);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    check("bp_sw_imm",   64'(bus_b.imm),         64'd4);
    check("bp_sw_alu",   64'(bus_b.alu_control), 64'hC);
    check("bp_sw_ready", 64'(bus_b.in_ready),    64'd1);
    tick();

    // Flush with a valid input while full
    drive(1'b1, 32'h0030_0093, 32'h0000_0300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0040_0113, 32'h0000_0304, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0050_0193, 32'h0000_0308, 1'b0, 1'b1);
    tick();
    zero_checks("flush");
    check("flush_ready", 64'(bus_b.in_ready), 64'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    check("flush_dropped", 64'(bus_b.out_valid), 64'd0);

    // beq x0,x0,-4 on both branch configurations
    drive(1'b1, 32'hFE00_0EE3, 32'h0000_0400, 1'b1, 1'b0);
    tick();
    check("beq_class",    64'(bus_b.inst_class),   64'd6);
    check("beq_imm",      64'(bus_b.imm),          64'hFFFF_FFFC);
    check("beq_alu",      64'(bus_b.alu_control),  64'h4);
    check("beq_nb_class", 64'(bus_nb.inst_class),  64'd7);
    check("beq_nb_alu",   64'(bus_nb.alu_control), 64'hF);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();

    // Asynchronous reset with two entries buffered
    drive(1'b1, 32'h0000_0537, 32'h0000_0500, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0597, 32'h0000_0504, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    zero_checks("mid_rst");
    qb.delete();  qnb.delete();  zeroed = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst_ready", 64'(bus_b.in_ready), 64'd1);

    // Full-rate streaming of legal instructions
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, rand_legal(), pc, 1'b1, 1'b0);
      pc += 32'd4;
      tick();
      if (bus_b.out_valid) cnt++;
    end
    check("stream_count", 64'(cnt), 64'd100);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();

    // Random traffic with stalls, flushes and arbitrary words
    for (int i = 0; i < 600; i++) begin
      w = ($urandom_range(0, 3) == 0) ? 32'($urandom) : rand_legal();
      drive($urandom_range(0, 3) != 0, w, pc, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
      pc += 32'd4;
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
